multiword_add_sequencer: RTL and testbench
==========================================

Name: multiword_add_sequencer

Overview:
- Multi-cycle controller that performs WORDS×32-bit add/subtract by sequencing one shared 32-bit carry-lookahead adder, least-significant word first.
- Chains carry between words through an internal carry register.
- Sits between an operand-issuing unit (Start/Done handshake) and the 32-bit CLA instance, which lives outside this block and is reached through the Add_* ports.

Parameters:
- WORDS, 4, number of 32-bit words per operand; legal range 2..16; operand width W = 32*WORDS.
- IDXW, 4, width of the word-index counter; must satisfy 2^IDXW >= WORDS.

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous active-low reset.
- Start  input  1  request; accepted only in IDLE.
- Sub  input  1  0 = A+B+Cin_ext, 1 = A−B (B inverted, carry-in forced to 1, Cin_ext ignored).
- Cin_ext  input  1  external carry-in for add.
- Op_A  input  W  operand A; sampled on accept.
- Op_B  input  W  operand B; sampled on accept.
- Add_A  output  32  to adder A.
- Add_B  output  32  to adder B; already inverted for Sub.
- Add_Cin  output  1  to adder carry-in.
- Add_Sum  input  32  from adder sum.
- Add_Cout  input  1  from adder carry-out.
- Busy  output  1  high in RUN and DONE.
- Done  output  1  one-cycle pulse; result valid.
- Result  output  W  sum/difference; held until the next accept.
- Cout  output  1  final carry-out. For Sub, 1 means no borrow.
- Overflow  output  1  two's-complement overflow of the full W-bit operation.

Behaviour:
- Reset (async, Rst_n=0) drives all registers to zero:
  - state=IDLE, idx=0, carry=0.
  - Result=0, Cout=0, Overflow=0, Busy=0, Done=0.
  - Add_A, Add_B and Add_Cin are 0.
  - Reset mid-operation abandons the operation with no Done pulse.
- States:
  - IDLE: Busy=0, Add_* driven 0.
    - Start=1 → latch Op_A, Op_B (B latched as ~Op_B if Sub), Sub.
    - Set idx=0, carry = Sub ? 1 : Cin_ext, go to RUN.
  - RUN: Add_A = A_reg word[idx], Add_B = B_reg word[idx], Add_Cin = carry (combinational from registers). Each edge:
    - Result word[idx] ← Add_Sum; carry ← Add_Cout.
    - If idx==WORDS−1 → Cout ← Add_Cout, Overflow ← (A_top[31]==B_top[31]) && (Add_Sum[31]!=A_top[31]), go to DONE.
    - Otherwise idx ← idx+1.
  - DONE: Done=1 and Busy=1 for exactly one cycle, Add_* driven 0, then go to IDLE.
- Latency:
  - Start sampled at edge 0 → RUN for WORDS cycles → Done high during cycle WORDS+1.
  - Earliest next Start acceptance is the edge that leaves DONE+1, i.e. while in IDLE.
  - Throughput is one operation per WORDS+2 cycles.
- Start in RUN or DONE is ignored and not queued. Operand changes after accept have no effect.
- Result is not cleared on accept. Words are overwritten progressively in RUN; Result is meaningful only from Done onward.
- Adder is assumed combinational, settling within one Clk period; no wait states.
- Sub with Op_B=0: B_reg=all ones, carry-in=1 → Result=Op_A, Cout=1.
- Carry-out of the top word is never wrapped into word 0.

Test Plan:
- Reset mid-RUN: assert Rst_n=0 during idx=1 → Busy, Done, Result, Cout all 0 immediately with no Done pulse; a following Start completes normally.
- Carry ripple across words (WORDS=4): Op_A=2^96−1 (words 0–2 all FFFFFFFF, word3=0), Op_B=1, Sub=0, Cin_ext=0 → Result=0x00000001_00000000_00000000_00000000, Cout=0, Overflow=0; Done exactly 5 cycles after the accept edge.
- Full wrap: Op_A=all ones, Op_B=0, Cin_ext=1 → Result=0, Cout=1, Overflow=0.
- Subtract with borrow: Op_A=5, Op_B=7, Sub=1 → Result=all ones except LSB (−2), Cout=0, Overflow=0. Swap operands → Result=2, Cout=1.
- Signed overflow: Op_A=0x7FFF…FFFF, Op_B=1, Sub=0 → Result=0x8000…0000, Overflow=1, Cout=0.
- Start ignored while busy: pulse Start with new operands during RUN and during DONE → a single Done for the original operation, then IDLE. Monitor confirms Add_Cin of word k equals Add_Cout of word k−1 on every RUN cycle.

Source files
------------

// File: rtl/multiword_add_sequencer.sv
// Multi-word add/subtract controller. Streams WORDS 32-bit slices of two
// latched operands through one external 32-bit adder, LS word first, chaining
// the carry between slices through an internal register.
module multiword_add_sequencer #(
    parameter int WORDS = 4,            // 32-bit words per operand, 2..16
    parameter int IDXW  = 4             // word-index width, 2**IDXW >= WORDS
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  Start,
    input  logic                  Sub,
    input  logic                  Cin_ext,
    input  logic [32*WORDS-1:0]   Op_A,
    input  logic [32*WORDS-1:0]   Op_B,
    output logic [31:0]           Add_A,
    output logic [31:0]           Add_B,
    output logic                  Add_Cin,
    input  logic [31:0]           Add_Sum,
    input  logic                  Add_Cout,
    output logic                  Busy,
    output logic                  Done,
    output logic [32*WORDS-1:0]   Result,
    output logic                  Cout,
    output logic                  Overflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [WORDS-1:0][31:0]   a_q, a_d;
    logic [WORDS-1:0][31:0]   b_q, b_d;      // already inverted for subtract
    logic [WORDS-1:0][31:0]   res_q, res_d;
    logic [IDXW-1:0]          idx_q, idx_d;
    logic                     carry_q, carry_d;
    logic                     cout_q, cout_d;
    logic                     ovf_q, ovf_d;

    logic [31:0]              a_word, b_word;
    logic                     last_word;
    logic                     run;

    assign run       = (state_q == S_RUN);
    assign last_word = (idx_q == IDXW'(WORDS - 1));

    // Select the operand slice addressed by the word index (compare-mux keeps
    // the index width independent of WORDS).
    always_comb begin
        a_word = '0;
        b_word = '0;
        for (int w = 0; w < WORDS; w++) begin
            if (idx_q == IDXW'(w)) begin
                a_word = a_q[w];
                b_word = b_q[w];
            end
        end
    end

    // Next-state and datapath update for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    a_d     = Op_A;
                    b_d     = Sub ? ~Op_B : Op_B;
                    idx_d   = '0;
                    carry_d = Sub ? 1'b1 : Cin_ext;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                for (int w = 0; w < WORDS; w++) begin
                    if (idx_q == IDXW'(w)) res_d[w] = Add_Sum;
                end
                carry_d = Add_Cout;
                if (last_word) begin
                    // Overflow judged on the effective (possibly inverted) B,
                    // so one rule covers both add and subtract.
                    cout_d  = Add_Cout;
                    ovf_d   = (a_q[WORDS-1][31] == b_q[WORDS-1][31]) &&
                              (Add_Sum[31] != a_q[WORDS-1][31]);
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Adder is only driven while a word is being processed.
    assign Add_A    = run ? a_word : 32'h0;
    assign Add_B    = run ? b_word : 32'h0;
    assign Add_Cin  = run & carry_q;

    assign Busy     = (state_q != S_IDLE);
    assign Done     = (state_q == S_DONE);
    assign Result   = res_q;
    assign Cout     = cout_q;
    assign Overflow = ovf_q;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Bench for multiword_add_sequencer: transaction-level reference model plus
// directed literal cases and randomized traffic.
module tb_multiword_add_sequencer;

    localparam int WORDS = 4;
    localparam int IDXW  = 4;
    localparam int W     = 32 * WORDS;

    logic          Clk = 1'b0;
    logic          Rst_n = 1'b0;
    logic          Start = 1'b0;
    logic          Sub = 1'b0;
    logic          Cin_ext = 1'b0;
    logic [W-1:0]  Op_A = '0;
    logic [W-1:0]  Op_B = '0;
    logic [31:0]   Add_A, Add_B, Add_Sum;
    logic          Add_Cin, Add_Cout;
    logic          Busy, Done, Cout, Overflow;
    logic [W-1:0]  Result;

    multiword_add_sequencer #(.WORDS(WORDS), .IDXW(IDXW)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Sub(Sub), .Cin_ext(Cin_ext),
        .Op_A(Op_A), .Op_B(Op_B), .Add_A(Add_A), .Add_B(Add_B),
        .Add_Cin(Add_Cin), .Add_Sum(Add_Sum), .Add_Cout(Add_Cout),
        .Busy(Busy), .Done(Done), .Result(Result), .Cout(Cout),
        .Overflow(Overflow)
    );

    // Ideal combinational 32-bit adder standing in for the external CLA.
    logic [32:0] add_full;
    assign add_full = {1'b0, Add_A} + {1'b0, Add_B} + {32'b0, Add_Cin};
    assign Add_Sum  = add_full[31:0];
    assign Add_Cout = add_full[32];

    always #5 Clk = ~Clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Whole-operand result: {overflow, carry-out, W-bit result}.
    function automatic logic [W+1:0] model_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic sub, input logic cin);
        logic [W-1:0] beff;
        logic [W:0]   s;
        logic         ovf;
        beff = sub ? ~b : b;
        s    = {1'b0, a} + {1'b0, beff} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
        ovf  = (a[W-1] == beff[W-1]) && (s[W-1] != a[W-1]);
        return {ovf, s[W], s[W-1:0]};
    endfunction

    // Carry entering bit 32*k of the full-width sum.
    function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic ci, input int k);
        logic [W:0] m, s;
        m = ({{W{1'b0}}, 1'b1} << (32 * k)) - 1'b1;
        s = ({1'b0, a} & m) + ({1'b0, b} & m) + {{W{1'b0}}, ci};
        return s[32 * k];
    endfunction

    // Reference model: m_cnt counts the busy cycles left for the current op
    // (WORDS word cycles, then one Done cycle).
    int            m_cnt = 0;
    logic [W-1:0]  m_a = '0, m_b = '0;
    logic          m_cin = 1'b0;
    logic [W+1:0]  p_pack = '0;
    logic [W-1:0]  e_res = '0;
    logic          e_cout = 1'b0, e_ovf = 1'b0;

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            m_cnt  <= 0;
            e_res  <= '0;
            e_cout <= 1'b0;
            e_ovf  <= 1'b0;
        end else if (m_cnt == 0) begin
            if (Start) begin
                m_a    <= Op_A;
                m_b    <= Sub ? ~Op_B : Op_B;
                m_cin  <= Sub ? 1'b1 : Cin_ext;
                p_pack <= model_op(Op_A, Op_B, Sub, Cin_ext);
                m_cnt  <= WORDS + 1;
            end
        end else begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 2) begin
                e_res  <= p_pack[W-1:0];
                e_cout <= p_pack[W];
                e_ovf  <= p_pack[W+1];
            end
        end
    end

    // Cycle-by-cycle compare against the model.
    logic prev_cout = 1'b0;
    always @(negedge Clk) begin
        if (Rst_n) begin
            check("busy", Busy, m_cnt != 0);
            check("done", Done, m_cnt == 1);
            if (m_cnt >= 2) begin
                check("add_a", Add_A, m_a[32*(WORDS+1-m_cnt) +: 32]);
                check("add_b", Add_B, m_b[32*(WORDS+1-m_cnt) +: 32]);
                check("add_cin", Add_Cin, carry_into(m_a, m_b, m_cin, WORDS + 1 - m_cnt));
                if (m_cnt <= WORDS) check("cin_chain", Add_Cin, prev_cout);
            end else begin
                check("add_a_idle", Add_A, '0);
                check("add_b_idle", Add_B, '0);
                check("add_cin_idle", Add_Cin, 1'b0);
                check("result", Result, e_res);
                check("cout", Cout, e_cout);
                check("overflow", Overflow, e_ovf);
            end
        end
        prev_cout <= Add_Cout;
    end

    // One directed operation with literal expectations.
    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic cin, input logic [W-1:0] er,
                          input logic ec, input logic eo, input logic chk_lat);
        int n;
        logic got;
        @(negedge Clk);
        Op_A = a; Op_B = b; Sub = sub; Cin_ext = cin; Start = 1'b1;
        @(posedge Clk);
        #1 Start = 1'b0;
        n = 0; got = 1'b0;
        while (!got && n < 40) begin
            @(negedge Clk);
            n++;
            if (Done) got = 1'b1;
        end
        check({name, "_done_seen"}, got, 1'b1);
        if (got) begin
            check({name, "_res"}, Result, er);
            check({name, "_cout"}, Cout, ec);
            check({name, "_ovf"}, Overflow, eo);
            if (chk_lat) check({name, "_latency"}, n, WORDS + 1);
        end
        @(negedge Clk);
    endtask

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] r;
        r = '0;
        case ($urandom_range(0, 5))
            0:       r = '0;
            1:       r = '1;
            2:       r = {1'b0, {(W-1){1'b1}}};
            3:       r = {1'b1, {(W-1){1'b0}}};
            default: for (int i = 0; i < WORDS; i++) r[32*i +: 32] = $urandom();
        endcase
        return r;
    endfunction

    initial begin
        int dones;
        logic [W-1:0] tmp;
        // Reset values
        #2;
        check("rst_result", Result, '0);
        check("rst_cout", Cout, 1'b0);
        check("rst_ovf", Overflow, 1'b0);
        check("rst_busy", Busy, 1'b0);
        check("rst_done", Done, 1'b0);
        check("rst_add_a", Add_A, '0);
        check("rst_add_b", Add_B, '0);
        check("rst_add_cin", Add_Cin, 1'b0);
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);

        // Directed cases with hand-computed results
        run_op("ripple", {32'h0, {96{1'b1}}}, 128'h1, 1'b0, 1'b0,
               128'h00000001_00000000_00000000_00000000, 1'b0, 1'b0, 1'b1);
        run_op("wrap", '1, '0, 1'b0, 1'b1, '0, 1'b1, 1'b0, 1'b1);
        run_op("sub_borrow", 128'h5, 128'h7, 1'b1, 1'b0,
               128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE, 1'b0, 1'b0, 1'b0);
        run_op("sub_swap", 128'h7, 128'h5, 1'b1, 1'b0, 128'h2, 1'b1, 1'b0, 1'b0);
        run_op("signed_ovf", 128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'h1, 1'b0, 1'b0,
               128'h80000000_00000000_00000000_00000000, 1'b0, 1'b1, 1'b0);
        run_op("sub_zero", 128'h01234567_89ABCDEF_FEDCBA98_76543210, '0, 1'b1, 1'b1,
               128'h01234567_89ABCDEF_FEDCBA98_76543210, 1'b1, 1'b0, 1'b0);

        // Start ignored in RUN and DONE
        @(negedge Clk);
        Op_A = 128'd100; Op_B = 128'd23; Sub = 1'b0; Cin_ext = 1'b0; Start = 1'b1;
        @(posedge Clk);
        #1;
        dones = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge Clk);
            if (Done) begin
                dones++;
                Op_A = 128'd9; Op_B = 128'd9; Start = 1'b1;
            end else if (i == 1) begin
                Op_A = 128'd1; Op_B = 128'd1; Sub = 1'b1; Start = 1'b1;
            end else begin
                Start = 1'b0;
            end
        end
        check("ignore_single_done", dones, 1);
        check("ignore_result", Result, 128'd123);
        check("ignore_idle", Busy, 1'b0);

        // Reset mid-RUN at idx=1
        @(negedge Clk);
        Op_A = 128'hDEAD_BEEF_0000_0001_1111_2222_3333_4444; Op_B = 128'h5; Sub = 1'b0;
        Start = 1'b1;
        @(posedge Clk);
        #1 Start = 1'b0;
        repeat (2) @(negedge Clk);
        #1 Rst_n = 1'b0;
        #1;
        check("mid_rst_busy", Busy, 1'b0);
        check("mid_rst_done", Done, 1'b0);
        check("mid_rst_result", Result, '0);
        check("mid_rst_cout", Cout, 1'b0);
        check("mid_rst_add_a", Add_A, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check("mid_rst_no_done", Done, 1'b0);
        end
        Rst_n = 1'b1;
        @(negedge Clk);
        run_op("after_rst", 128'h10, 128'h20, 1'b0, 1'b1, 128'h31, 1'b0, 1'b0, 1'b1);

        // Randomized traffic, including Start pulses while busy
        for (int c = 0; c < 600; c++) begin
            @(negedge Clk);
            tmp     = rand_w();
            Op_A    = tmp;
            Op_B    = rand_w();
            Sub     = 1'($urandom_range(0, 1));
            Cin_ext = 1'($urandom_range(0, 1));
            Start   = ($urandom_range(0, 2) == 0);
        end
        @(negedge Clk);
        Start = 1'b0;
        repeat (WORDS + 3) @(negedge Clk);
        check("final_idle", Busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
